// File: rtl/axi_slave_read.sv
// AXI read-channel responder: accepts one AR at a time and streams arlen+1 R beats
// from the 4 KiB byte memory using FIXED/INCR/WRAP address sequencing.
module axi_slave_read #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [4095:0][7:0]    slave_mem,
    input  logic [3:0]            arid,
    input  logic [WIDTH-1:0]      araddr,
    input  logic [3:0]            arlen,
    input  logic [SIZE-1:0]       arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [3:0]            rid,
    output logic [WIDTH-1:0]      rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state, state_nxt;
    logic [11:0]       addr_q;
    logic [3:0]        len_q, cnt_q;
    logic [SIZE-1:0]   size_q;
    logic [1:0]        burst_q;
    logic              err_q;

    logic              accept, advance, done, err_in, wrap_len_ok;
    logic [11:0]       amask, bytes, total, base, next_addr, ld_addr;
    logic [SIZE-1:0]   ld_size;
    logic              ld_err;
    logic [WIDTH-1:0]  ld_data;
    logic [2:0]        lb, lend;
    logic [1:0]        lal;
    logic              unused_addr;

    assign unused_addr = ^araddr[WIDTH-1:12];

    assign accept  = (state == IDLE) && arvalid;
    assign advance = (state == BURST) && rready;
    assign done    = advance && (cnt_q == len_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arvalid) state_nxt = BURST;
            BURST:   if (done)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        arready     = (state == IDLE);
        amask       = (12'd1 << arsize) - 12'd1;
        wrap_len_ok = (arlen == 4'd1) || (arlen == 4'd3) || (arlen == 4'd7) || (arlen == 4'd15);
        err_in      = (arsize > SIZE'(2)) || (arburst == 2'b11) ||
                      ((arburst == 2'b10) && (!wrap_len_ok || ((araddr[11:0] & amask) != 12'd0)));

        bytes     = 12'd1 << size_q;
        total     = ({8'd0, len_q} + 12'd1) << size_q;
        base      = addr_q & ~(total - 12'd1);
        next_addr = addr_q;
        case (burst_q)
            2'b01:   next_addr = (addr_q & ~(bytes - 12'd1)) + bytes;
            2'b10:   begin
                next_addr = addr_q + bytes;
                if (next_addr == base + total) next_addr = base;
            end
            default: next_addr = addr_q;
        endcase

        // Beat 0 is built from the AR inputs; later beats from the stepped address.
        if (state == IDLE) begin
            ld_addr = araddr[11:0];
            ld_size = arsize;
            ld_err  = err_in;
        end else begin
            ld_addr = next_addr;
            ld_size = size_q;
            ld_err  = err_q;
        end

        lb      = 3'd1 << ld_size[1:0];
        lal     = ld_addr[1:0] & ~(lb[1:0] - 2'd1);
        lend    = {1'b0, lal} + lb;
        ld_data = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (!ld_err && (3'(k) >= {1'b0, ld_addr[1:0]}) && (3'(k) < lend))
                ld_data[8*k +: 8] = slave_mem[{ld_addr[11:2], 2'(k)}];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= 2'b00;
            rlast   <= 1'b0;
            rvalid  <= 1'b0;
        end else if (accept) begin
            addr_q  <= araddr[11:0];
            len_q   <= arlen;
            cnt_q   <= '0;
            size_q  <= arsize;
            burst_q <= arburst;
            err_q   <= err_in;
            rid     <= arid;
            rdata   <= ld_data;
            rresp   <= err_in ? 2'b10 : 2'b00;
            rlast   <= (arlen == 4'd0);
            rvalid  <= 1'b1;
        end else if (advance) begin
            if (done) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end else begin
                addr_q <= next_addr;
                cnt_q  <= cnt_q + 4'd1;
                rdata  <= ld_data;
                rlast  <= ((cnt_q + 4'd1) == len_q);
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_read.sv
// Scoreboard bench for axi_slave_read: directed AR requests push expected beats,
// a negedge monitor pops and compares every R handshake.
module tb_axi_slave_read;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
        logic [3:0]  id;
    } beat_t;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [4095:0][7:0] mem;
    logic [3:0]        arid = '0;
    logic [31:0]       araddr = '0;
    logic [3:0]        arlen = '0;
    logic [2:0]        arsize = '0;
    logic [1:0]        arburst = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [3:0]        rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready = 1'b1;

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t sb[$];
    beat_t e;

    axi_slave_read #(.WIDTH(32), .SIZE(3)) dut (
        .clk(clk), .resetn(resetn), .slave_mem(mem),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_beat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] r, input logic l);
        beat_t b;
        b.d = d; b.r = r; b.l = l; b.id = id;
        sb.push_back(b);
    endtask

    task automatic exp_err(input logic [3:0] id, input int n);
        for (int i = 0; i < n; i++) exp_beat(id, 32'h0, 2'b10, i == n - 1);
    endtask

    task automatic issue(input logic [3:0] id, input logic [11:0] a, input logic [3:0] len,
                         input logic [2:0] sz, input logic [1:0] br);
        @(posedge clk); #1;
        arid = id; araddr = {20'h0, a}; arlen = len; arsize = sz; arburst = br; arvalid = 1'b1;
        chk("arready_idle", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() > 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", sb.size());
            sb.delete();
        end
        #1;
        chk("idle_rvalid", 32'(rvalid), 32'd0);
        chk("idle_arready", 32'(arready), 32'd1);
    endtask

    always @(negedge clk) begin
        if (resetn && rvalid && rready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_beat: got rdata %h expected no beat", rdata);
            end else begin
                e = sb.pop_front();
                chk("beat_data", rdata, e.d);
                chk("beat_resp", 32'(rresp), 32'(e.r));
                chk("beat_last", 32'(rlast), 32'(e.l));
                chk("beat_id", 32'(rid), 32'(e.id));
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_rid", 32'(rid), 32'd0);
        resetn = 1'b1;

        // INCR aligned
        exp_beat(4'h5, 32'h13121110, 2'b00, 1'b0);
        exp_beat(4'h5, 32'h17161514, 2'b00, 1'b0);
        exp_beat(4'h5, 32'h1B1A1918, 2'b00, 1'b0);
        exp_beat(4'h5, 32'h1F1E1D1C, 2'b00, 1'b1);
        issue(4'h5, 12'h010, 4'd3, 3'd2, 2'b01);
        chk("incr_first_latency", 32'(rvalid), 32'd1);
        drain();

        // WRAP
        exp_beat(4'h6, 32'h1B1A1918, 2'b00, 1'b0);
        exp_beat(4'h6, 32'h1F1E1D1C, 2'b00, 1'b0);
        exp_beat(4'h6, 32'h13121110, 2'b00, 1'b0);
        exp_beat(4'h6, 32'h17161514, 2'b00, 1'b1);
        issue(4'h6, 12'h018, 4'd3, 3'd2, 2'b10);
        drain();

        // FIXED with rready pattern 1,0,0,1
        rready = 1'b0;
        exp_beat(4'h7, 32'h03000000, 2'b00, 1'b0);
        exp_beat(4'h7, 32'h03000000, 2'b00, 1'b1);
        issue(4'h7, 12'h003, 4'd1, 3'd0, 2'b00);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stall_rvalid", 32'(rvalid), 32'd1);
            chk("stall_rdata", rdata, 32'h03000000);
            chk("stall_rlast", 32'(rlast), 32'd1);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        drain();

        // Unaligned INCR start: beat 0 carries only upper lanes
        exp_beat(4'h8, 32'h23222100, 2'b00, 1'b0);
        exp_beat(4'h8, 32'h27262524, 2'b00, 1'b1);
        issue(4'h8, 12'h021, 4'd1, 3'd2, 2'b01);
        drain();

        // Error cases
        exp_err(4'h1, 3);
        issue(4'h1, 12'h000, 4'd2, 3'd2, 2'b11);
        drain();
        exp_err(4'h2, 3);
        issue(4'h2, 12'h000, 4'd2, 3'd3, 2'b01);
        drain();
        exp_err(4'h3, 3);
        issue(4'h3, 12'h000, 4'd2, 3'd2, 2'b10);
        drain();
        exp_err(4'h4, 4);
        issue(4'h4, 12'h012, 4'd3, 3'd2, 2'b10);
        drain();

        // INCR across the top of the 4 KiB space
        exp_beat(4'hB, 32'hFFFEFDFC, 2'b00, 1'b0);
        exp_beat(4'hB, 32'h03020100, 2'b00, 1'b1);
        issue(4'hB, 12'hFFC, 4'd1, 3'd2, 2'b01);
        drain();

        // Reset pulsed during beat 1 of a 4-beat burst
        exp_beat(4'h9, 32'h43424140, 2'b00, 1'b0);
        issue(4'h9, 12'h040, 4'd3, 3'd2, 2'b01);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_arready", 32'(arready), 32'd1);
        chk("midrst_rlast", 32'(rlast), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
        resetn = 1'b1;

        // New AR after reset
        exp_beat(4'hA, 32'h13121110, 2'b00, 1'b0);
        exp_beat(4'hA, 32'h17161514, 2'b00, 1'b0);
        exp_beat(4'hA, 32'h1B1A1918, 2'b00, 1'b0);
        exp_beat(4'hA, 32'h1F1E1D1C, 2'b00, 1'b1);
        issue(4'hA, 12'h010, 4'd3, 3'd2, 2'b01);
        drain();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
